// File: rtl/instr_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder.
//   - Default instruction/address widths.
//   - FSM state encoding for the fetch sequencer (IDLE / WAIT / RESP).
//   - NOP encoding returned for entries that were never loaded.
//   - Helper that computes the last wait-counter value for a wait-state count.
package instr_fetch_responder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // Counter value at which WAIT hands over to RESP. With zero wait states
  // WAIT is never entered, so the returned value is irrelevant there.
  function automatic logic [3:0] wait_last(input int wait_cycles);
    if (wait_cycles > 0) begin
      wait_last = 4'(wait_cycles - 1);
    end else begin
      wait_last = 4'd0;
    end
  endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch/load bus between the CPU fetch logic and the instruction responder.
//   master (CPU side)      : drives fetch_req, fetch_addr, load_en, load_addr, load_data
//   slave  (responder side): drives fetch_ready, raw_instruction, instr_valid,
//                            fetch_err, busy
interface instr_fetch_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic [DATA_W-1:0] raw_instruction;
  logic              instr_valid;
  logic              fetch_err;
  logic              busy;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (
    output fetch_req, fetch_addr, load_en, load_addr, load_data,
    input  fetch_ready, raw_instruction, instr_valid, fetch_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, load_en, load_addr, load_data,
    output fetch_ready, raw_instruction, instr_valid, fetch_err, busy
  );

endinterface

// File: rtl/instr_fetch_responder_instr_store.sv
// instr_store: 2**ADDR_W x DATA_W program store with a synchronous write port
// and a registered read port.
//   clk, rst  : clock, asynchronous active-low reset (clears array and read reg)
//   we/waddr/wdata : write port, takes effect at the rising edge
//   rd_en/raddr    : when rd_en is high the addressed word is captured into rd_data
//   rd_data        : registered read data, held between reads
//   rd_err         : registered "entry never loaded" flag (FETCH_ERR_EN only, else 0)
// Read and write share the edge: the read register samples the array before the
// write lands, so a same-edge write to the read address returns the old word.
// Optional feature macro: FETCH_ERR_EN adds per-entry loaded bits; a read of an
// unloaded entry returns NOP with rd_err set.
module instr_store
  import instr_fetch_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef FETCH_ERR_EN
  logic [DEPTH-1:0] loaded_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded_q <= '0;
    end else if (we) begin
      loaded_q[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= NOP_W;
      rd_err  <= 1'b0;
    end else if (rd_en) begin
      rd_data <= loaded_q[raddr] ? mem[raddr] : NOP_W;
      rd_err  <= ~loaded_q[raddr];
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= NOP_W;
    end else if (rd_en) begin
      rd_data <= mem[raddr];
    end
  end

  assign rd_err = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: answers CPU instruction fetches from a small program
// store after WAIT_CYCLES wait states.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset; aborts any fetch in flight
//   bus  : instr_fetch_responder_if.slave
//          fetch_req/fetch_addr in, fetch_ready out (high only in IDLE)
//          raw_instruction out (registered, held until next response)
//          instr_valid out (one-cycle pulse in RESP), fetch_err out (with instr_valid)
//          busy out (WAIT or RESP), load_en/load_addr/load_data in (write any state)
// Parameters: DATA_W (16), ADDR_W (3), WAIT_CYCLES (1, range 0..15).
// Optional feature macro: FETCH_ERR_EN -- fetches of never-loaded entries return
// NOP with fetch_err; without it fetch_err is always 0.
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_fetch_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_LAST = wait_last(WAIT_CYCLES);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

  fetch_state_t      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // rd_en marks the edge that enters RESP; the store captures the word then.
  // With no wait states that edge is the accept edge itself, so the read
  // address comes straight from the request rather than from addr_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      IDLE: begin
        rd_addr = bus.fetch_addr;
        if (bus.fetch_req) begin
          addr_d = bus.fetch_addr;
          cnt_d  = '0;
          if (HAS_WAIT) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            rd_en   = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  instr_store #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.load_en),
    .waddr   (bus.load_addr),
    .wdata   (bus.load_data),
    .rd_en   (rd_en),
    .raddr   (rd_addr),
    .rd_data (rd_data),
    .rd_err  (rd_err)
  );

  assign bus.fetch_ready     = (state_q == IDLE);
  assign bus.busy            = (state_q != IDLE);
  assign bus.instr_valid     = (state_q == RESP);
  assign bus.raw_instruction = rd_data;
  // rd_err is held with the read data; only report it during the response.
  assign bus.fetch_err       = (state_q == RESP) & rd_err;

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-side responder for the CPU fetch path: holds an 8-entry, 16-bit program store and answers CPU fetch requests (address = `pc`) with `raw_instruction` after a fixed number of wait states. A separate load port writes the program before or during execution. It is the counterpart of the CPU's fetch logic and is the source of every `raw_instruction` the CPU decodes into `op_code`/`source_reg_one`.

## Interface
- `DATA_W`, 16, instruction width
- `ADDR_W`, 3, address width; depth = 2**ADDR_W (8)
- `WAIT_CYCLES`, 1, wait states between accept and response (0–15)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fetch_req`  in  1  CPU fetch request
- `fetch_addr`  in  ADDR_W  fetch address (CPU `pc`)
- `fetch_ready`  out  1  high only in IDLE; request accepted when `fetch_req && fetch_ready` at a rising edge
- `raw_instruction`  out  DATA_W  returned instruction, registered, held until next response
- `instr_valid`  out  1  one-cycle pulse marking `raw_instruction` as new
- `fetch_err`  out  1  error flag, coincident with `instr_valid`
- `busy`  out  1  high in WAIT or RESP
- `load_en`  in  1  program-store write enable
- `load_addr`  in  ADDR_W  write address
- `load_data`  in  DATA_W  write data

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `fetch_ready`=1. On accept: capture `fetch_addr` into `addr_q`; go to WAIT if `WAIT_CYCLES`>0 (counter cleared), else RESP.
- WAIT: counter increments each edge; at the edge where counter = `WAIT_CYCLES`-1, go to RESP.
- On the edge entering RESP: `raw_instruction` <= store[`addr_q`]; `instr_valid` high for exactly the RESP cycle; RESP -> IDLE unconditionally.
- `fetch_req` outside IDLE is ignored, never queued; CPU must hold/reissue.
- Load: `load_en` writes store[`load_addr`] at the rising edge in any state.
- Same-edge collision (load to `addr_q` on the edge entering RESP): response returns the old word (read-before-write); new word visible to later fetches.
- Address arithmetic: no wrap or bounds logic needed; all ADDR_W values are in range.

## Timing
- Reset (async, `rst`=0): state IDLE, counter 0, `addr_q`=0, `raw_instruction`=16'h0000, `instr_valid`=0, `fetch_err`=0, `busy`=0, `fetch_ready`=1 once released; store cleared to 0.
- Reset asserted mid-WAIT/RESP aborts the fetch; no `instr_valid` is produced for it.
- Latency: request accepted at edge E0 -> `instr_valid` high in the cycle after edge E0+`WAIT_CYCLES`.
- Throughput: one fetch per `WAIT_CYCLES`+2 cycles; next accept at the first edge after RESP.
- `raw_instruction` changes only on edges entering RESP or on reset.

## Configuration
- `FETCH_ERR_EN` defined: per-entry loaded bit, cleared by reset, set by `load_en`. A fetch of a never-loaded entry returns `raw_instruction`=16'h0000 (NOP) with `fetch_err`=1 for the RESP cycle.
- Not defined: no loaded bits; `fetch_err` tied 0; unloaded entries return their reset value 0.

## Structure
- Shared package: `DATA_W`/`ADDR_W` defaults, FSM state encoding (IDLE/WAIT/RESP), NOP constant 16'h0000.
- One sub-module: `instr_store` (8×16 array, sync write, read-before-write, optional loaded bits under `FETCH_ERR_EN`); FSM and wait counter stay in the top.

## Test plan
- Reset then idle: `rst`=0 mid-cycle -> all outputs at reset values immediately; `fetch_ready`=1 after release.
- Load store[2]=16'hA5C3, `WAIT_CYCLES`=1, fetch addr 2 at E0 -> `instr_valid` pulse after E1 with `raw_instruction`=16'hA5C3, `busy`=1 for 2 cycles.
- `WAIT_CYCLES`=0, back-to-back fetches of addr 0 then 7 with `fetch_req` held -> responses every 2 cycles, correct words, extra requests during RESP ignored.
- Collision: store[4]=16'h1111, load 16'h2222 to addr 4 on the edge entering RESP -> returns 16'h1111; next fetch of 4 returns 16'h2222.
- `FETCH_ERR_EN`: fetch unloaded addr 5 -> `raw_instruction`=0, `fetch_err`=1 with `instr_valid`; without macro `fetch_err` stays 0.
- Assert `rst` during WAIT -> no `instr_valid`, state IDLE, `raw_instruction`=0.
